// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              fifo_full,
    input  logic              fifo_almost_full,
    output logic              fifo_wr_en,
    output logic [7:0]        fifo_data_in,
    output logic              grant_valid,
    output logic [2:0]        grant_id,
    output logic [3:0]        beat_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0] r_state,    w_state_nxt;
    logic [2:0] r_grant_id, w_grant_id_nxt;
    logic [3:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [2:0] r_rr_ptr,   w_rr_ptr_nxt;

    // Inputs padded to the full 8-requester width so a 3-bit index is always legal.
    logic [7:0]  w_valid_pad;
    logic [7:0]  w_last_pad;
    logic [63:0] w_data_pad;
    logic [7:0]  w_ready_pad;

    assign w_valid_pad = 8'(req_valid);
    assign w_last_pad  = 8'(req_last);
    assign w_data_pad  = 64'(req_data);

    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[2:0];
    endfunction

    logic       w_sel_found;
    logic [2:0] w_sel_idx;
    logic [2:0] w_cand;

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = wrap_add(r_rr_ptr, k);
            if (!w_sel_found && w_valid_pad[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    logic w_in_burst;
    logic w_transfer;
    logic w_end_beat;
    logic w_abandon;

    assign w_in_burst = (r_state == S_BURST);
    assign w_transfer = w_in_burst && w_valid_pad[r_grant_id] && !fifo_full;
    assign w_end_beat = w_transfer &&
                        (w_last_pad[r_grant_id] || (r_beat_cnt == 4'(BURST - 1)));
    assign w_abandon  = w_in_burst && !w_valid_pad[r_grant_id];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= 3'(NREQ - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                // Almost-full only blocks new grants; bursts already running are untouched.
                if (w_sel_found && !fifo_almost_full) begin
                    w_state_nxt    = S_BURST;
                    w_grant_id_nxt = w_sel_idx;
                    w_rr_ptr_nxt   = w_sel_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_BURST: begin
                if (w_end_beat || w_abandon) begin
                    w_state_nxt    = S_IDLE;
                    w_beat_cnt_nxt = '0;
                end else if (w_transfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_pad  = '0;
        fifo_data_in = '0;
        if (w_in_burst) begin
            w_ready_pad[r_grant_id] = !fifo_full;
            fifo_data_in            = w_data_pad[{r_grant_id, 3'b000} +: 8];
        end
    end

    assign req_ready   = w_ready_pad[NREQ-1:0];
    assign fifo_wr_en  = w_transfer;
    assign grant_valid = w_in_burst;
    assign grant_id    = r_grant_id;
    assign beat_cnt    = r_beat_cnt;

endmodule
`default_nettype wire
